sounder_rx_sync: RTL and testbench
==================================

SOUNDER_RX_SYNC -- requirements
Module: sounder_rx_sync

Interface
REQ-001 Parameter WIDTH, default 32: bits per sample item.
REQ-002 Parameter NIPC, default 2: items per beat; must be a power of two.
REQ-003 The block SHALL use reset rst, synchronous, active-high; clock clk.
REQ-004 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_axis_tdata  in  NIPC*WIDTH  input samples
- i_axis_tkeep  in  NIPC  item valid
- i_axis_tlast  in  1  end of input packet
- i_axis_tvalid  in  1
- i_axis_tready  out  1
- i_axis_ttimestamp  in  64  time of the first item of the packet
- i_axis_thas_time  in  1  timestamp valid
- o_axis_tdata/tkeep/tlast/tvalid  out  as input
- o_axis_tready  in  1
- o_axis_ttimestamp  out  64  time of the first item of the output packet
- o_axis_thas_time  out  1
- arm  in  1  one-cycle pulse: capture start_time and begin waiting
- disarm  in  1  one-cycle pulse: stop forwarding
- start_time  in  64  sample time at which forwarding starts
- state_o  out  2  current state
- drop_cnt  out  32  beats dropped since arm, saturating
- late_err  out  1  sticky late-start flag (macro only, else tied 0)

Function
REQ-005 The block SHALL track beat_time: on the first beat of a packet with thas_time=1, load ttimestamp; on every other accepted beat, beat_time = previous + NIPC (64-bit wrap).
REQ-006 First beat of a packet SHALL be the first beat after reset or after an accepted tlast.
REQ-007 States SHALL be IDLE=0, WAIT=1, RUN=2.
REQ-008 IDLE: all input beats accepted and dropped; arm -> WAIT, start_time registered.
REQ-009 WAIT: beats with beat_time + NIPC - 1 < start_reg dropped; the first beat with beat_time + NIPC - 1 >= start_reg is forwarded, and the state goes to RUN in the same cycle.
REQ-010 RUN: all beats forwarded unchanged; disarm SHALL be latched and the state SHALL return to IDLE after the next accepted tlast, which is forwarded.
REQ-011 disarm in WAIT -> IDLE immediately; arm in RUN or WAIT is ignored; arm and disarm in the same cycle -> disarm wins.
REQ-012 Output stage: single register, latency 1 cycle; i_axis_tready = ~o_axis_tvalid | o_axis_tready; no beat is lost or duplicated under backpressure.
REQ-013 Dropped beats SHALL consume no output cycle; i_axis_tready stays governed by REQ-012.
REQ-014 The first forwarded beat and every first beat of a forwarded packet SHALL carry o_axis_thas_time=1 and o_axis_ttimestamp=beat_time; all other beats carry thas_time=0.
REQ-015 Forwarded tlast SHALL equal input tlast; a packet entered mid-way is forwarded as a shortened packet ending at its tlast.
REQ-016 drop_cnt SHALL clear on arm, increment per dropped beat in WAIT, and saturate at 2^32-1.
REQ-017 A start_time not aligned to NIPC SHALL start at the beat containing it; items before it in that beat are forwarded unchanged.

Reset
REQ-018 On rst: state IDLE, o_axis_tvalid=0, o_axis_tlast=0, o_axis_thas_time=0, o_axis_ttimestamp=0, drop_cnt=0, late_err=0, beat_time=0, first-beat flag=1, disarm latch=0.
REQ-019 rst mid-packet SHALL discard the output register contents; the next beat is treated as a first beat.

Configuration
REQ-020 Macro SOUNDER_RX_SYNC_LATE_ERR_EN defined: if the first beat evaluated in WAIT already has beat_time > start_reg, late_err SHALL be set (sticky until arm) and the state SHALL return to IDLE without forwarding.
REQ-021 Macro undefined: the late case SHALL start forwarding immediately per REQ-009, and late_err SHALL be tied to 0.

Structure
REQ-022 Package sounder_pkg SHALL hold the state encoding constants (IDLE/WAIT/RUN) and the drop counter width.
REQ-023 The output register stage SHALL be one sub-module, axis_reg_stage; the FSM and time tracking SHALL be in the top level.

Verification
REQ-024 NIPC=2, packets of 8 beats with ts=0,16,32; arm with start_time=20 -> first output beat has ts=20 and thas_time=1, 6 beats until tlast, drop_cnt=10.
REQ-025 start_time=21 -> first output beat has ts=20.
REQ-026 o_axis_tready toggling 50% random in RUN -> output sequence equals the input sequence bit-exactly, and the last of 3 beats is not lost.
REQ-027 disarm mid-packet in RUN -> the remaining beats up to and including tlast are forwarded, then state_o=0 and no further output.
REQ-028 Macro defined, arm with start_time=5 while ts=100 -> late_err=1, state_o=0, no output; macro undefined -> output starts at ts=100.
REQ-029 rst asserted during RUN with o_axis_tvalid=1 -> next cycle o_axis_tvalid=0 and state_o=0.

Source files
------------

// File: rtl/sounder_pkg.sv
// Shared constants for the sounder receive-side start synchroniser: FSM
// state encoding and drop counter width.
package sounder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int DROP_CNT_W = 32;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sounder_rx_sync_if.sv
// AXI-stream style sample bus with a per-packet 64-bit timestamp sideband;
// master drives payload/valid, slave drives ready.
interface sounder_rx_sync_if #(
    parameter int WIDTH = 32,
    parameter int NIPC  = 2
);
    logic [NIPC*WIDTH-1:0] tdata;
    logic [NIPC-1:0]       tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;
    logic [63:0]           ttimestamp;
    logic                  thas_time;

    modport master (
        output tdata, tkeep, tlast, tvalid, ttimestamp, thas_time,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid, ttimestamp, thas_time,
        output tready
    );
endinterface

// File: rtl/axis_reg_stage.sv
// Single-entry output register for a valid/ready stream: one cycle latency,
// accepts a new word whenever it is empty or being drained in the same cycle.
module axis_reg_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    assign s_ready = !valid_q || m_ready;
    assign m_valid = valid_q;
    assign m_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_ready) begin
            valid_d = s_valid;
            if (s_valid) begin
                data_d = s_data;
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: payload is cleared too so tlast/timestamp read zero after reset.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/sounder_rx_sync.sv
// Drops incoming sample beats until a programmed start time, then forwards
// them with a fresh timestamp. Optional late-start error: SOUNDER_RX_SYNC_LATE_ERR_EN.
module sounder_rx_sync
    import sounder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIPC  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sounder_rx_sync_if.slave      i_axis,
    sounder_rx_sync_if.master     o_axis,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic [63:0]           start_time,
    output logic [1:0]            state_o,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  late_err
);
    localparam int          DW     = NIPC * WIDTH;
    localparam int          PW     = DW + NIPC + 1 + 64 + 1;
    localparam logic [63:0] NIPC64 = 64'(NIPC);

    state_e                  state_q, state_d;
    logic [63:0]             beat_time_q, beat_time_d;
    logic [63:0]             start_q, start_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    first_q, first_d;
    logic                    disarm_lat_q, disarm_lat_d;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
    logic                    late_q, late_d;
    logic                    wait_first_q, wait_first_d;
`endif

    logic [63:0]   cur_time;
    logic          reached;
    logic          accept;
    logic          fwd;
    logic          out_has_time;
    logic          s_ready;
    logic          m_valid;
    logic [PW-1:0] s_data, m_data;

    always_comb begin
        state_d      = state_q;
        beat_time_d  = beat_time_q;
        start_d      = start_q;
        drop_d       = drop_q;
        first_d      = first_q;
        disarm_lat_d = disarm_lat_q;
        fwd          = 1'b0;
        out_has_time = 1'b0;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
        late_d       = late_q;
        wait_first_d = wait_first_q;
`endif

        // Time of the beat on the input bus right now.
        cur_time = (first_q && i_axis.thas_time) ? i_axis.ttimestamp : beat_time_q + NIPC64;
        reached  = (cur_time + NIPC64 - 64'd1) >= start_q;
        accept   = i_axis.tvalid && s_ready;

        if (accept) begin
            beat_time_d = cur_time;
            first_d     = i_axis.tlast;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm && !disarm) begin
                    state_d      = ST_WAIT;
                    start_d      = start_time;
                    drop_d       = '0;
                    disarm_lat_d = 1'b0;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
                    late_d       = 1'b0;
                    wait_first_d = 1'b1;
`endif
                end
            end
            ST_WAIT: begin
                if (disarm) begin
                    state_d = ST_IDLE;
                end
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
                else if (wait_first_q && (cur_time > start_q)) begin
                    if (accept) begin
                        late_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`endif
                else if (reached) begin
                    fwd          = 1'b1;
                    out_has_time = 1'b1;
                    if (accept) begin
                        state_d = ST_RUN;
                    end
                end else if (accept) begin
                    drop_d = sat_inc(drop_q);
                end
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
                if (accept) begin
                    wait_first_d = 1'b0;
                end
`endif
            end
            ST_RUN: begin
                fwd          = 1'b1;
                out_has_time = first_q;
                if (disarm) begin
                    disarm_lat_d = 1'b1;
                end
                // A pending stop takes effect once the packet in flight closes.
                if (accept && i_axis.tlast && (disarm_lat_q || disarm)) begin
                    state_d      = ST_IDLE;
                    disarm_lat_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_time_q  <= '0;
            start_q      <= '0;
            drop_q       <= '0;
            first_q      <= 1'b1;
            disarm_lat_q <= 1'b0;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
            late_q       <= 1'b0;
            wait_first_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_time_q  <= beat_time_d;
            start_q      <= start_d;
            drop_q       <= drop_d;
            first_q      <= first_d;
            disarm_lat_q <= disarm_lat_d;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
            late_q       <= late_d;
            wait_first_q <= wait_first_d;
`endif
        end
    end

    assign s_data = {i_axis.tdata, i_axis.tkeep, i_axis.tlast,
                     out_has_time ? cur_time : 64'd0, out_has_time};

    axis_reg_stage #(.DW(PW)) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .s_valid (i_axis.tvalid && fwd),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (o_axis.tready),
        .m_data  (m_data)
    );

    assign i_axis.tready = s_ready;
    assign o_axis.tvalid = m_valid;
    assign {o_axis.tdata, o_axis.tkeep, o_axis.tlast,
            o_axis.ttimestamp, o_axis.thas_time} = m_data;

    assign state_o  = state_q;
    assign drop_cnt = drop_q;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
    assign late_err = late_q;
`else
    assign late_err = 1'b0;
`endif

endmodule

// File: tb/tb_sounder_rx_sync.sv
// Scoreboard bench for sounder_rx_sync: expected beats are queued as stimulus
// is driven and popped by an output monitor on the falling clock edge.
module tb_sounder_rx_sync;
    import sounder_pkg::*;

    localparam int WIDTH = 32;
    localparam int NIPC  = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
        logic        ht;
        logic [63:0] ts;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, disarm;
    logic [63:0] start_time;
    logic [1:0]  state_o;
    logic [31:0] drop_cnt;
    logic        late_err;

    logic        rand_ready;
    logic        ready_val;
    logic        started;
    int          n_checks;
    int          n_fail;
    int          n_out;
    beat_t       exp_q[$];

    sounder_rx_sync_if #(.WIDTH(WIDTH), .NIPC(NIPC)) i_axis ();
    sounder_rx_sync_if #(.WIDTH(WIDTH), .NIPC(NIPC)) o_axis ();

    sounder_rx_sync #(.WIDTH(WIDTH), .NIPC(NIPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_axis     (i_axis),
        .o_axis     (o_axis),
        .arm        (arm),
        .disarm     (disarm),
        .start_time (start_time),
        .state_o    (state_o),
        .drop_cnt   (drop_cnt),
        .late_err   (late_err)
    );

    always #5 clk = ~clk;

    initial begin
        o_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && o_axis.tvalid && o_axis.tready) begin
            n_out++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got data=%h last=%b, required no output",
                         o_axis.tdata, o_axis.tlast);
            end else begin
                e = exp_q.pop_front();
                if ({o_axis.tdata, o_axis.tkeep, o_axis.tlast, o_axis.thas_time} !==
                        {e.data, e.keep, e.last, e.ht} ||
                    (e.ht && (o_axis.ttimestamp !== e.ts))) begin
                    n_fail++;
                    $display("FAIL out_beat: got data=%h keep=%b last=%b ht=%b ts=%0d, required data=%h keep=%b last=%b ht=%b ts=%0d",
                             o_axis.tdata, o_axis.tkeep, o_axis.tlast, o_axis.thas_time, o_axis.ttimestamp,
                             e.data, e.keep, e.last, e.ht, e.ts);
                end
            end
        end
    end

    task automatic do_reset();
        rst               = 1'b1;
        arm               = 1'b0;
        disarm            = 1'b0;
        start_time        = '0;
        rand_ready        = 1'b0;
        ready_val         = 1'b1;
        i_axis.tvalid     = 1'b0;
        i_axis.tdata      = '0;
        i_axis.tkeep      = '0;
        i_axis.tlast      = 1'b0;
        i_axis.ttimestamp = '0;
        i_axis.thas_time  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        started = 1'b0;
    endtask

    task automatic arm_pulse(input logic [63:0] s, input logic with_disarm);
        arm        = 1'b1;
        disarm     = with_disarm;
        start_time = s;
        @(posedge clk);
        #1;
        arm    = 1'b0;
        disarm = 1'b0;
    endtask

    task automatic disarm_pulse();
        disarm = 1'b1;
        @(posedge clk);
        #1;
        disarm = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [1:0] keep, input logic last,
                             input logic [63:0] ts, input logic ht, input logic fwd,
                             input logic [63:0] exp_ts, input logic exp_ht, input logic dis);
        beat_t b;
        int    n;
        if (fwd) begin
            b.data = data;
            b.keep = keep;
            b.last = last;
            b.ht   = exp_ht;
            b.ts   = exp_ts;
            exp_q.push_back(b);
        end
        i_axis.tdata      = data;
        i_axis.tkeep      = keep;
        i_axis.tlast      = last;
        i_axis.ttimestamp = ts;
        i_axis.thas_time  = ht;
        i_axis.tvalid     = 1'b1;
        disarm            = dis;
        n = 0;
        forever begin
            @(negedge clk);
            if (i_axis.tready) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got tready=0 for %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_axis.tvalid = 1'b0;
        disarm        = 1'b0;
    endtask

    // Beats at times ts0, ts0+2, ...; a beat is expected at the output when
    // en is set and the beat covers or passes thr.
    task automatic send_pkt(input logic [63:0] ts0, input int nb, input logic [63:0] thr,
                            input logic en, input int dis_at);
        logic [63:0] t;
        logic        f;
        logic        eh;
        for (int i = 0; i < nb; i++) begin
            t  = ts0 + 64'(2 * i);
            f  = en && ((t + 64'd1) >= thr);
            eh = f && ((i == 0) || !started);
            if (f) started = 1'b1;
            send_beat({$urandom, $urandom}, (i == nb - 1) ? 2'b01 : 2'b11, i == nb - 1,
                      (i == 0) ? ts0 : {$urandom, $urandom}, i == 0, f, t, eh, i == dis_at);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats still pending, required 0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", state_o); end
        if (o_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b, required 0", o_axis.tvalid); end
        if (o_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b, required 0", o_axis.tlast); end
        if (o_axis.thas_time !== 1'b0) begin n_fail++; $display("FAIL rst_has_time: got %b, required 0", o_axis.thas_time); end
        if (o_axis.ttimestamp !== 64'd0) begin n_fail++; $display("FAIL rst_ts: got %0d, required 0", o_axis.ttimestamp); end
        if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt); end
        if (late_err !== 1'b0) begin n_fail++; $display("FAIL rst_late: got %b, required 0", late_err); end
        @(negedge clk);
        n_checks++;
        if (i_axis.tready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", i_axis.tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_drop();
        do_reset();
        send_pkt(64'd0, 4, 64'd0, 1'b0, -1);
        drain();
        n_checks += 2;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d, required 0", state_o); end
        if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL idle_drop: got %0d, required 0", drop_cnt); end
    endtask

    task automatic test_start_aligned();
        int out0;
        do_reset();
        arm_pulse(64'd20, 1'b0);
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL arm_state: got %0d, required 1", state_o); end
        out0 = n_out;
        send_pkt(64'd0, 8, 64'd20, 1'b1, -1);
        send_pkt(64'd16, 8, 64'd20, 1'b1, -1);
        drain();
        n_checks += 3;
        if (drop_cnt !== 32'd10) begin n_fail++; $display("FAIL start20_drop: got %0d, required 10", drop_cnt); end
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL start20_state: got %0d, required 2", state_o); end
        if (n_out - out0 !== 6) begin n_fail++; $display("FAIL start20_beats: got %0d, required 6", n_out - out0); end
        send_pkt(64'd32, 4, 64'd0, 1'b1, -1);
        drain();
        n_checks++;
        if (drop_cnt !== 32'd10) begin n_fail++; $display("FAIL run_drop_hold: got %0d, required 10", drop_cnt); end
    endtask

    task automatic test_start_unaligned();
        do_reset();
        arm_pulse(64'd21, 1'b0);
        send_pkt(64'd16, 8, 64'd21, 1'b1, -1);
        drain();
        n_checks++;
        if (drop_cnt !== 32'd2) begin n_fail++; $display("FAIL start21_drop: got %0d, required 2", drop_cnt); end
    endtask

    task automatic test_back_to_back_backpressure();
        int out0;
        do_reset();
        arm_pulse(64'd0, 1'b0);
        out0 = n_out;
        rand_ready = 1'b1;
        send_pkt(64'd0, 3, 64'd0, 1'b1, -1);
        send_pkt(64'd6, 8, 64'd0, 1'b1, -1);
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 2;
        if (n_out - out0 !== 11) begin n_fail++; $display("FAIL bp_beats: got %0d, required 11", n_out - out0); end
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL bp_state: got %0d, required 2", state_o); end
    endtask

    task automatic test_disarm_run();
        int out0;
        do_reset();
        arm_pulse(64'd0, 1'b0);
        out0 = n_out;
        send_pkt(64'd0, 8, 64'd0, 1'b1, 3);
        drain();
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL disarm_state: got %0d, required 0", state_o); end
        send_pkt(64'd16, 4, 64'd0, 1'b0, -1);
        drain();
        n_checks++;
        if (n_out - out0 !== 8) begin n_fail++; $display("FAIL disarm_beats: got %0d, required 8", n_out - out0); end
    endtask

    task automatic test_arm_rules();
        do_reset();
        arm_pulse(64'd0, 1'b1);
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL arm_disarm_same: got %0d, required 0", state_o); end
        arm_pulse(64'd1000, 1'b0);
        disarm_pulse();
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL disarm_wait: got %0d, required 0", state_o); end
        arm_pulse(64'd1000, 1'b0);
        arm_pulse(64'd0, 1'b0);
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL rearm_ignored: got %0d, required 1", state_o); end
        send_pkt(64'd0, 8, 64'd1000, 1'b1, -1);
        drain();
        n_checks += 2;
        if (drop_cnt !== 32'd8) begin n_fail++; $display("FAIL wait_drop: got %0d, required 8", drop_cnt); end
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL wait_hold: got %0d, required 1", state_o); end
        disarm_pulse();
    endtask

    task automatic test_late();
        int out0;
        do_reset();
        arm_pulse(64'd5, 1'b0);
        out0 = n_out;
`ifdef SOUNDER_RX_SYNC_LATE_ERR_EN
        send_pkt(64'd100, 4, 64'd0, 1'b0, -1);
        drain();
        n_checks += 3;
        if (late_err !== 1'b1) begin n_fail++; $display("FAIL late_flag: got %b, required 1", late_err); end
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL late_state: got %0d, required 0", state_o); end
        if (n_out - out0 !== 0) begin n_fail++; $display("FAIL late_beats: got %0d, required 0", n_out - out0); end
        arm_pulse(64'd200, 1'b0);
        n_checks++;
        if (late_err !== 1'b0) begin n_fail++; $display("FAIL late_clear: got %b, required 0", late_err); end
`else
        send_pkt(64'd100, 4, 64'd0, 1'b1, -1);
        drain();
        n_checks += 3;
        if (late_err !== 1'b0) begin n_fail++; $display("FAIL late_flag: got %b, required 0", late_err); end
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL late_state: got %0d, required 2", state_o); end
        if (n_out - out0 !== 4) begin n_fail++; $display("FAIL late_beats: got %0d, required 4", n_out - out0); end
`endif
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        arm_pulse(64'd0, 1'b0);
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        send_beat(64'h1234_5678_9abc_def0, 2'b11, 1'b0, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
        n_checks += 2;
        if (o_axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b, required 1", o_axis.tvalid); end
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL pre_rst_state: got %0d, required 2", state_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (o_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, required 0", o_axis.tvalid); end
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state: got %0d, required 0", state_o); end
        rst = 1'b0;
        exp_q.delete();
        started   = 1'b0;
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        arm_pulse(64'd50, 1'b0);
        send_pkt(64'd50, 4, 64'd0, 1'b1, -1);
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;
        test_reset();
        test_idle_drop();
        test_start_aligned();
        test_start_unaligned();
        test_back_to_back_backpressure();
        test_disarm_run();
        test_arm_rules();
        test_late();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
